// File: rtl/gesummv_run_ctrl.sv
// Job-level ap_ctrl_hs run controller for the gesummv core: accepts jobs, runs the core, reports latency.
// Build option: define GESUMMV_RUN_CTRL_TIMEOUT_EN to compile in the watchdog and FLUSH state.
module gesummv_run_ctrl #(
  parameter int unsigned CYCLE_W        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [31:0]        job_alpha,
  input  logic [31:0]        job_beta,
  output logic               acc_start,
  input  logic               acc_ready,
  input  logic               acc_done,
  input  logic               acc_idle,
  output logic [31:0]        acc_alpha,
  output logic [31:0]        acc_beta,
  output logic               acc_rst,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [CYCLE_W-1:0] resp_cycles,
  output logic               resp_timeout,
  output logic               busy
);

  // state | meaning
  // IDLE  | waiting for a job; job_ready follows acc_idle
  // START | ap_start held high until the core reports ap_ready
  // RUN   | core started, waiting for ap_done
  // FLUSH | watchdog fired; core held in soft reset for 2 cycles
  // RESP  | response presented until resp_ready
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
`ifdef GESUMMV_RUN_CTRL_TIMEOUT_EN
    S_FLUSH = 3'd3,
`endif
    S_RESP  = 3'd4
  } state_t;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  state_t             state_q;
  logic [CYCLE_W-1:0] cnt_q;
  logic [CYCLE_W-1:0] cnt_d;
  logic [CYCLE_W-1:0] resp_cycles_q;
  logic [31:0]        alpha_q;
  logic [31:0]        beta_q;
  logic               acc_start_q;
  logic               resp_valid_q;
  logic               busy_q;
  logic               accept;
  logic               run_done;

  assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CYCLE_W'(1);
  assign job_ready = (state_q == S_IDLE) && acc_idle && !ap_rst;
  assign accept    = job_valid && job_ready;
  // In START, done only counts when the core also reports ready that cycle.
  assign run_done  = acc_done && (acc_ready || (state_q == S_RUN));

`ifdef GESUMMV_RUN_CTRL_TIMEOUT_EN
  logic acc_rst_q;
  logic resp_timeout_q;
  logic flush_q;
  logic wd_hit;

  assign wd_hit       = (cnt_q == CYCLE_W'(TIMEOUT_CYCLES));
  assign acc_rst      = acc_rst_q;
  assign resp_timeout = resp_timeout_q;
`else
  assign acc_rst      = 1'b0;
  assign resp_timeout = 1'b0;
`endif

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      resp_cycles_q  <= '0;
      alpha_q        <= '0;
      beta_q         <= '0;
      acc_start_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
`ifdef GESUMMV_RUN_CTRL_TIMEOUT_EN
      acc_rst_q      <= 1'b0;
      resp_timeout_q <= 1'b0;
      flush_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            alpha_q     <= job_alpha;
            beta_q      <= job_beta;
            cnt_q       <= CYCLE_W'(1);
            acc_start_q <= 1'b1;
            busy_q      <= 1'b1;
`ifdef GESUMMV_RUN_CTRL_TIMEOUT_EN
            resp_timeout_q <= 1'b0;
`endif
            state_q     <= S_START;
          end
        end
        S_START, S_RUN: begin
          if (run_done) begin
            resp_cycles_q <= cnt_q;
            resp_valid_q  <= 1'b1;
            acc_start_q   <= 1'b0;
            state_q       <= S_RESP;
          end
`ifdef GESUMMV_RUN_CTRL_TIMEOUT_EN
          else if (wd_hit) begin
            resp_cycles_q <= cnt_q;
            acc_start_q   <= 1'b0;
            acc_rst_q     <= 1'b1;
            flush_q       <= 1'b0;
            state_q       <= S_FLUSH;
          end
`endif
          else begin
            cnt_q <= cnt_d;
            if ((state_q == S_START) && acc_ready) begin
              acc_start_q <= 1'b0;
              state_q     <= S_RUN;
            end
          end
        end
`ifdef GESUMMV_RUN_CTRL_TIMEOUT_EN
        S_FLUSH: begin
          if (flush_q) begin
            acc_rst_q      <= 1'b0;
            resp_valid_q   <= 1'b1;
            resp_timeout_q <= 1'b1;
            state_q        <= S_RESP;
          end else begin
            flush_q <= 1'b1;
          end
        end
`endif
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign acc_start   = acc_start_q;
  assign acc_alpha   = alpha_q;
  assign acc_beta    = beta_q;
  assign resp_valid  = resp_valid_q;
  assign resp_cycles = resp_cycles_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_gesummv_run_ctrl.sv
// Directed bench for gesummv_run_ctrl: table of job vectors plus hand sequences for gating, reset and watchdog.
module tb_gesummv_run_ctrl;

`ifdef GESUMMV_RUN_CTRL_TIMEOUT_EN
  localparam int AUX_W = 32;
`else
  localparam int AUX_W = 4;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        job_valid, job_ready;
  logic [31:0] job_alpha, job_beta;
  logic        acc_start, acc_ready, acc_done, acc_idle;
  logic [31:0] acc_alpha, acc_beta;
  logic        acc_rst, resp_valid, resp_ready, resp_timeout, busy;
  logic [31:0] resp_cycles;

  logic             x_job_valid, x_job_ready;
  logic [31:0]      x_acc_alpha, x_acc_beta;
  logic             x_acc_start, x_acc_ready, x_acc_done, x_acc_idle;
  logic             x_acc_rst, x_resp_valid, x_resp_ready, x_resp_timeout, x_busy;
  logic [AUX_W-1:0] x_resp_cycles;

  always #5 ap_clk = ~ap_clk;

  gesummv_run_ctrl #(.CYCLE_W(32), .TIMEOUT_CYCLES(4096)) u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_alpha(job_alpha), .job_beta(job_beta),
    .acc_start(acc_start), .acc_ready(acc_ready), .acc_done(acc_done), .acc_idle(acc_idle),
    .acc_alpha(acc_alpha), .acc_beta(acc_beta), .acc_rst(acc_rst),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_cycles(resp_cycles), .resp_timeout(resp_timeout), .busy(busy)
  );

  // Narrow counter for saturation in the default build; 16-cycle watchdog in the timeout build.
  gesummv_run_ctrl #(.CYCLE_W(AUX_W), .TIMEOUT_CYCLES(16)) u_aux (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .job_valid(x_job_valid), .job_ready(x_job_ready),
    .job_alpha(32'h1111_2222), .job_beta(32'h3333_4444),
    .acc_start(x_acc_start), .acc_ready(x_acc_ready), .acc_done(x_acc_done), .acc_idle(x_acc_idle),
    .acc_alpha(x_acc_alpha), .acc_beta(x_acc_beta), .acc_rst(x_acc_rst),
    .resp_valid(x_resp_valid), .resp_ready(x_resp_ready),
    .resp_cycles(x_resp_cycles), .resp_timeout(x_resp_timeout), .busy(x_busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] alpha;
    logic [31:0] beta;
    int          ready_at;
    int          done_at;
    int          stall;
    logic [31:0] exp_cycles;
    int          exp_start;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic run_job(input vec_t v);
    int  starts = 0;
    int  bad = 0;
    bit  seen = 0;
    job_alpha  = v.alpha;
    job_beta   = v.beta;
    job_valid  = 1'b1;
    acc_idle   = 1'b1;
    resp_ready = 1'b0;
    #1 chk("job_ready_idle", job_ready, 1);
    step();
    job_valid = 1'b0;
    acc_idle  = 1'b0;
    #1;
    chk("acc_alpha", acc_alpha, v.alpha);
    chk("acc_beta", acc_beta, v.beta);
    for (int k = 1; k <= 2000; k++) begin
      acc_ready = (k == v.ready_at);
      acc_done  = (k == v.done_at);
      #1;
      if (acc_start) starts++;
      if (job_ready || !busy || resp_valid) bad++;
      step();
      if (k == v.done_at) begin
        seen = 1'b1;
        break;
      end
    end
    acc_ready = 1'b0;
    acc_done  = 1'b0;
    chk("done_seen", seen, 1);
    chk("run_gating", bad, 0);
    chk("start_cycles", starts, v.exp_start);
    chk("resp_valid", resp_valid, 1);
    chk("resp_cycles", resp_cycles, v.exp_cycles);
    chk("resp_timeout", resp_timeout, 0);
    bad = 0;
    for (int s = 0; s < v.stall; s++) begin
      if (!resp_valid || resp_cycles !== v.exp_cycles || job_ready || acc_start) bad++;
      step();
    end
    chk("resp_hold", bad, 0);
    resp_ready = 1'b1;
    acc_idle   = 1'b1;
    step();
    resp_ready = 1'b0;
    #1;
    chk("post_resp_valid", resp_valid, 0);
    chk("post_resp_busy", busy, 0);
    chk("post_resp_job_ready", job_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int rst_pulses;
    bit got;
    vecs[0] = '{32'h3FC0_0000, 32'h4000_0000, 100, 100, 0, 32'd100, 100};
    vecs[1] = '{32'hAAAA_0001, 32'h5555_0002,   3,  50, 0, 32'd50,    3};
    vecs[2] = '{32'h0000_0001, 32'h8000_0000,   1,   1, 0, 32'd1,     1};
    vecs[3] = '{32'hDEAD_BEEF, 32'hCAFE_F00D,   2,   7, 5, 32'd7,     2};
    vecs[4] = '{32'h1234_5678, 32'h9ABC_DEF0,   1,  30, 1, 32'd30,    1};

    ap_rst = 1'b1;
    job_valid = 1'b0; job_alpha = '0; job_beta = '0;
    acc_ready = 1'b0; acc_done = 1'b0; acc_idle = 1'b1; resp_ready = 1'b0;
    x_job_valid = 1'b0; x_acc_ready = 1'b0; x_acc_done = 1'b0; x_acc_idle = 1'b1; x_resp_ready = 1'b0;
    #3;
    chk("rst_ctrl_outs", {job_ready, acc_start, acc_rst, resp_valid, resp_timeout, busy}, 0);
    chk("rst_acc_alpha", acc_alpha, 0);
    chk("rst_acc_beta", acc_beta, 0);
    chk("rst_resp_cycles", resp_cycles, 0);
    step();
    step();
    ap_rst = 1'b0;
    #1 chk("job_ready_after_rst", job_ready, 1);

    for (int i = 0; i < 5; i++) run_job(vecs[i]);

    // spurious done/ready while idle
    acc_done = 1'b1; acc_ready = 1'b1;
    step();
    acc_done = 1'b0; acc_ready = 1'b0;
    #1;
    chk("spurious_state", {resp_valid, busy, acc_start, job_ready}, 4'b0001);
    chk("spurious_alpha_kept", acc_alpha, vecs[4].alpha);

    // idle gating, then backpressure with a second job pending
    acc_idle = 1'b0; job_valid = 1'b1; job_alpha = 32'hA1A1_A1A1; job_beta = 32'hB1B1_B1B1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      #1 if (job_ready || busy) bad++;
      step();
    end
    chk("idle_gating", bad, 0);
    acc_idle = 1'b1;
    #1 chk("idle_release_ready", job_ready, 1);
    step();
    acc_idle = 1'b0; job_alpha = 32'hA2A2_A2A2; job_beta = 32'hB2B2_B2B2;
    acc_ready = 1'b1; acc_done = 1'b1;
    #1 chk("job1_alpha", acc_alpha, 32'hA1A1_A1A1);
    step();
    acc_ready = 1'b0; acc_done = 1'b0;
    chk("bp_resp", {resp_valid, resp_cycles}, {1'b1, 32'd1});
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      #1 if (job_ready || !resp_valid || resp_cycles !== 32'd1 || acc_alpha !== 32'hA1A1_A1A1) bad++;
      step();
    end
    chk("bp_hold", bad, 0);
    acc_idle = 1'b1; resp_ready = 1'b1;
    #1 chk("bp_handshake_ready", job_ready, 0);
    step();
    resp_ready = 1'b0;
    #1 chk("bp_after_hs", {job_ready, acc_start, busy}, 3'b100);
    step();
    job_valid = 1'b0; acc_idle = 1'b0;
    #1;
    chk("job2_alpha", acc_alpha, 32'hA2A2_A2A2);
    chk("job2_start", {acc_start, busy}, 2'b11);
    acc_ready = 1'b1; acc_done = 1'b1;
    step();
    acc_ready = 1'b0; acc_done = 1'b0;
    chk("job2_resp", {resp_valid, resp_cycles}, {1'b1, 32'd1});
    resp_ready = 1'b1; acc_idle = 1'b1;
    step();
    resp_ready = 1'b0;

    // reset in cycle 10 of RUN
    job_valid = 1'b1; job_alpha = 32'h0BAD_0BAD; job_beta = 32'h0F0F_0F0F;
    #1 chk("rstrun_accept_ready", job_ready, 1);
    step();
    job_valid = 1'b0; acc_idle = 1'b0;
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    for (int c = 1; c < 10; c++) step();
    ap_rst = 1'b1;
    #1;
    chk("rstrun_ctrl_outs", {job_ready, acc_start, acc_rst, resp_valid, resp_timeout, busy}, 0);
    chk("rstrun_alpha", acc_alpha, 0);
    chk("rstrun_beta", acc_beta, 0);
    chk("rstrun_cycles", resp_cycles, 0);
    step();
    ap_rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      acc_done = (c == 3);
      #1 if (resp_valid || busy || acc_start) bad++;
      step();
    end
    acc_done = 1'b0;
    chk("rstrun_no_resp", bad, 0);
    run_job(vecs[3]);

`ifdef GESUMMV_RUN_CTRL_TIMEOUT_EN
    // watchdog: core never reports done
    x_job_valid = 1'b1;
    step();
    x_job_valid = 1'b0; x_acc_idle = 1'b0;
    rst_pulses = 0; got = 1'b0; bad = 0;
    for (int k = 1; k <= 100; k++) begin
      x_acc_ready = (k == 1);
      #1;
      if (x_acc_rst) rst_pulses++;
      if (x_acc_rst && x_acc_start) bad++;
      if (x_resp_valid) begin
        got = 1'b1;
        break;
      end
      step();
    end
    x_acc_ready = 1'b0;
    chk("wd_resp_seen", got, 1);
    chk("wd_rst_cycles", rst_pulses, 2);
    chk("wd_start_low", bad, 0);
    chk("wd_resp_timeout", x_resp_timeout, 1);
    chk("wd_resp_cycles", 32'(x_resp_cycles), 32'd16);
    x_resp_ready = 1'b1; x_acc_idle = 1'b1;
    step();
    x_resp_ready = 1'b0;
    #1 chk("wd_back_idle", {x_resp_valid, x_busy, x_acc_rst}, 0);
`else
    // 4-bit counter saturates at 15 on a 20-cycle run
    x_job_valid = 1'b1;
    #1 chk("sat_job_ready", x_job_ready, 1);
    step();
    x_job_valid = 1'b0; x_acc_idle = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      x_acc_ready = (k == 1);
      x_acc_done  = (k == 20);
      step();
    end
    x_acc_ready = 1'b0; x_acc_done = 1'b0;
    chk("sat_resp_valid", x_resp_valid, 1);
    chk("sat_resp_cycles", 32'(x_resp_cycles), 32'd15);
    chk("sat_resp_timeout", x_resp_timeout, 0);
    x_resp_ready = 1'b1; x_acc_idle = 1'b1;
    step();
    x_resp_ready = 1'b0;
    #1 chk("sat_back_idle", {x_resp_valid, x_busy, x_job_ready}, 3'b001);
    rst_pulses = 0;
    got = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
